// File: rtl/coinc_trigger_matrix.sv
// Coincidence trigger matrix: per-trigger mode/threshold/dead time, shared prescale gate and
// saturating hit/fire histograms. Define ROLLING_TRIG_EN to build the periodic rolling trigger.
module coinc_trigger_matrix #(
    parameter int NCH       = 16,
    parameter int NROW      = 4,
    parameter int NTRIG     = 8,
    parameter int TW        = 8,
    parameter int CW        = $clog2(NCH + 1),
    parameter int HW        = 32,
    parameter int ROLL_BITS = 20
) (
    input  logic                clk_adc,
    input  logic                nrst,
    input  logic [NCH-1:0]      coax_in,
    input  logic [TW-1:0]       coincidence_time,
    input  logic [2*NTRIG-1:0]  trig_mode,
    input  logic [CW*NTRIG-1:0] trig_thr,
    input  logic [TW*NTRIG-1:0] dead_time,
    input  logic [TW-1:0]       out_width,
    input  logic [NTRIG-1:0]    prescale_en,
    input  logic [31:0]         randnum,
    input  logic [31:0]         prescale,
    input  logic                resethist,
    input  logic [7:0]          hist_sel,
    output logic [HW-1:0]       hist_out,
    output logic [NTRIG-1:0]    trig_out,
    output logic                fire_toggle,
    input  logic                dorolling,
    output logic                ext_trig_out
);
    localparam int NGRP = NCH / NROW;
    localparam int NBIN = NCH + NTRIG;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (&v) ? v : v + HW'(1);
    endfunction

    function automatic logic [TW-1:0] dec_to_zero(input logic [TW-1:0] v);
        return (v != '0) ? v - TW'(1) : v;
    endfunction

    logic [NCH-1:0]   hit_q, hit_d1_q;
    logic [TW-1:0]    tin_q [NCH];
    logic [TW-1:0]    tin_d [NCH];
    logic [NCH-1:0]   active;
    logic [CW-1:0]    nrow_q [NROW];
    logic [CW-1:0]    nrow_d [NROW];
    logic [CW-1:0]    ntot, rows;
    logic [31:0]      randnum_q, prescale_q;
    logic             pass_q;
    logic [NTRIG-1:0] cond, fire;
    logic [TW-1:0]    tout_q [NTRIG];
    logic [TW-1:0]    tout_d [NTRIG];
    logic [TW-1:0]    dead_q [NTRIG];
    logic [TW-1:0]    dead_d [NTRIG];
    logic [NTRIG-1:0] trig_q, trig_d;
    logic [HW-1:0]    bin_q [NBIN];
    logic [HW-1:0]    bin_d [NBIN];
    logic [HW-1:0]    hist_q, hist_d;
    logic             toggle_q;

    // Input stage: hold timers and row occupancy
    always_comb begin
        for (int j = 0; j < NCH; j++) begin
            tin_d[j]  = hit_q[j] ? coincidence_time : dec_to_zero(tin_q[j]);
            active[j] = (tin_q[j] > TW'(2));
        end
        for (int r = 0; r < NROW; r++) begin
            nrow_d[r] = '0;
            for (int g = 0; g < NGRP; g++)
                nrow_d[r] = nrow_d[r] + CW'(active[r*NGRP + g]);
        end
        ntot = '0;
        rows = '0;
        for (int r = 0; r < NROW; r++) begin
            ntot = ntot + nrow_q[r];
            if (nrow_q[r] != '0)
                rows = rows + CW'(1);
        end
    end

    // Decision stage: trigger conditions, fire, output and dead timers
    always_comb begin
        logic [CW-1:0] thr;
        logic [1:0]    md;
        logic          any_row;
        cond = '0;
        fire = '0;
        for (int k = 0; k < NTRIG; k++) begin
            thr     = trig_thr[CW*k +: CW];
            md      = trig_mode[2*k +: 2];
            any_row = 1'b0;
            for (int r = 0; r < NROW; r++)
                if (nrow_q[r] >= thr)
                    any_row = 1'b1;
            case (md)
                2'd0:    cond[k] = (ntot >= thr);
                2'd1:    cond[k] = any_row;
                2'd2:    cond[k] = any_row && (rows == CW'(1));
                default: cond[k] = 1'b0;
            endcase
            // Zero threshold free-runs in every enabled mode, including the single-row mode
            if (md != 2'd3 && thr == '0)
                cond[k] = 1'b1;
            fire[k]   = (dead_q[k] == '0) && cond[k] && (pass_q || !prescale_en[k]);
            tout_d[k] = fire[k] ? out_width : dec_to_zero(tout_q[k]);
            dead_d[k] = fire[k] ? dead_time[TW*k +: TW] : dec_to_zero(dead_q[k]);
            trig_d[k] = (tout_q[k] != '0);
        end
    end

    // Histogram bins and readout mux
    always_comb begin
        for (int j = 0; j < NCH; j++)
            bin_d[j] = (hit_q[j] && !hit_d1_q[j]) ? sat_inc(bin_q[j]) : bin_q[j];
        for (int k = 0; k < NTRIG; k++)
            bin_d[NCH + k] = fire[k] ? sat_inc(bin_q[NCH + k]) : bin_q[NCH + k];
        if (resethist)
            for (int i = 0; i < NBIN; i++)
                bin_d[i] = '0;
        hist_d = '0;
        for (int i = 0; i < NBIN; i++)
            if (hist_sel == 8'(i))
                hist_d = bin_q[i];
    end

    always_ff @(posedge clk_adc) begin
        if (!nrst) begin
            hit_q      <= '0;
            hit_d1_q   <= '0;
            tin_q      <= '{default: '0};
            nrow_q     <= '{default: '0};
            randnum_q  <= '0;
            prescale_q <= '0;
            pass_q     <= 1'b0;
            tout_q     <= '{default: '0};
            dead_q     <= '{default: '0};
            trig_q     <= '0;
            bin_q      <= '{default: '0};
            hist_q     <= '0;
            toggle_q   <= 1'b0;
        end else begin
            hit_q      <= ~coax_in;
            hit_d1_q   <= hit_q;
            tin_q      <= tin_d;
            nrow_q     <= nrow_d;
            randnum_q  <= randnum;
            prescale_q <= prescale;
            pass_q     <= (randnum_q <= prescale_q);
            tout_q     <= tout_d;
            dead_q     <= dead_d;
            trig_q     <= trig_d;
            bin_q      <= bin_d;
            hist_q     <= hist_d;
            toggle_q   <= toggle_q ^ fire[0];
        end
    end

    assign trig_out    = trig_q;
    assign hist_out    = hist_q;
    assign fire_toggle = toggle_q;

`ifdef ROLLING_TRIG_EN
    logic [ROLL_BITS:0] auto_q, auto_d;
    logic [2:0]         roll_q, roll_d;

    // Autocounter wraps after reaching 2^ROLL_BITS, giving a 2^ROLL_BITS+1 cycle period
    always_comb begin
        auto_d = auto_q + (ROLL_BITS + 1)'(1);
        roll_d = (roll_q != 3'd0) ? roll_q - 3'd1 : roll_q;
        if (auto_q[ROLL_BITS]) begin
            auto_d = '0;
            if (dorolling)
                roll_d = 3'd4;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (!nrst) begin
            auto_q <= '0;
            roll_q <= 3'd0;
        end else begin
            auto_q <= auto_d;
            roll_q <= roll_d;
        end
    end

    assign ext_trig_out = (roll_q != 3'd0);
`else
    logic unused_dorolling;
    assign unused_dorolling = dorolling;
    assign ext_trig_out     = 1'b0;
`endif

endmodule

// File: tb/tb_coinc_trigger_matrix.sv
// Scoreboard bench for coinc_trigger_matrix: expectations queued at stimulus time, popped at output.
`timescale 1ns/1ps
module tb_coinc_trigger_matrix;
    localparam int NCH   = 16;
    localparam int NROW  = 4;
    localparam int NTRIG = 8;
    localparam int TW    = 8;
    localparam int CW    = $clog2(NCH + 1);
    localparam int HW    = 4;
    localparam int RB    = 4;
    localparam int NBIN  = NCH + NTRIG;

    logic                clk_adc = 1'b0;
    logic                nrst = 1'b0;
    logic [NCH-1:0]      coax_in = '1;
    logic [TW-1:0]       coincidence_time = '0;
    logic [2*NTRIG-1:0]  trig_mode = '1;
    logic [CW*NTRIG-1:0] trig_thr = '0;
    logic [TW*NTRIG-1:0] dead_time = '0;
    logic [TW-1:0]       out_width = '0;
    logic [NTRIG-1:0]    prescale_en = '0;
    logic [31:0]         randnum = '0;
    logic [31:0]         prescale = '0;
    logic                resethist = 1'b0;
    logic [7:0]          hist_sel = '0;
    logic [HW-1:0]       hist_out;
    logic [NTRIG-1:0]    trig_out;
    logic                fire_toggle;
    logic                dorolling = 1'b0;
    logic                ext_trig_out;

    coinc_trigger_matrix #(
        .NCH(NCH), .NROW(NROW), .NTRIG(NTRIG), .TW(TW), .CW(CW), .HW(HW), .ROLL_BITS(RB)
    ) dut (
        .clk_adc(clk_adc), .nrst(nrst), .coax_in(coax_in),
        .coincidence_time(coincidence_time), .trig_mode(trig_mode), .trig_thr(trig_thr),
        .dead_time(dead_time), .out_width(out_width), .prescale_en(prescale_en),
        .randnum(randnum), .prescale(prescale), .resethist(resethist), .hist_sel(hist_sel),
        .hist_out(hist_out), .trig_out(trig_out), .fire_toggle(fire_toggle),
        .dorolling(dorolling), .ext_trig_out(ext_trig_out)
    );

    always #5 clk_adc = ~clk_adc;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk_eq("sb_underflow", got, 32'hDEAD_BEEF ^ got);
        end else begin
            e = sb_q.pop_front();
            chk_eq(e.tag, got, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk_adc);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic read_bin(input int idx, output logic [HW-1:0] v);
        hist_sel = 8'(idx);
        tick();
        v = hist_out;
    endtask

    task automatic disable_all();
        trig_mode   = '1;
        trig_thr    = '0;
        dead_time   = '0;
        prescale_en = '0;
    endtask

    task automatic set_trig(input int k, input logic [1:0] mode, input int thr, input int dt);
        trig_mode[2*k +: 2]  = mode;
        trig_thr[CW*k +: CW] = CW'(thr);
        dead_time[TW*k +: TW] = TW'(dt);
    endtask

    task automatic pulse_hit(input int ch);
        coax_in[ch] = 1'b0;
        tick();
        coax_in = '1;
        tick();
    endtask

    // One-cycle hit on the given channels; trig_out is quiet until E4, then must equal exp4
    task automatic pulse_check(input logic [NCH-1:0] hits, input logic [NTRIG-1:0] exp4,
                               input string tag);
        for (int i = 0; i < 4; i++)
            sb_push($sformatf("%s_e%0d", tag, i), 32'd0);
        sb_push({tag, "_e4"}, 32'(exp4));
        coax_in = ~hits;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0)
                coax_in = '1;
            sb_check(32'(trig_out));
        end
        idle(40);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [HW-1:0] v;
        int            hi, lo, t;

        // Reset state
        nrst = 1'b0;
        idle(3);
        chk_eq("rst_trig", 32'(trig_out), 32'd0);
        chk_eq("rst_hist", 32'(hist_out), 32'd0);
        chk_eq("rst_toggle", 32'(fire_toggle), 32'd0);
        chk_eq("rst_ext", 32'(ext_trig_out), 32'd0);
        nrst = 1'b1;
        idle(3);

        // Single hit on channel 5: pulse E4..E19
        disable_all();
        coincidence_time = 8'd3;
        out_width        = 8'd16;
        set_trig(0, 2'd0, 1, 0);
        coax_in[5] = 1'b0;
        for (int i = 0; i <= 20; i++)
            sb_push($sformatf("single_e%0d", i), (i >= 4 && i <= 19) ? 32'd1 : 32'd0);
        for (int i = 0; i <= 20; i++) begin
            tick();
            if (i == 0)
                coax_in = '1;
            sb_check(32'(trig_out));
        end
        idle(5);
        sb_push("single_bin5", 32'd1);
        read_bin(5, v);
        sb_check(32'(v));
        sb_push("single_bin16", 32'd1);
        read_bin(16, v);
        sb_check(32'(v));
        chk_eq("single_toggle", 32'(fire_toggle), 32'd1);

        // Row logic
        disable_all();
        coincidence_time = 8'd10;
        out_width        = 8'd4;
        set_trig(1, 2'd1, 2, 0);
        set_trig(2, 2'd2, 3, 0);
        pulse_check(16'h0007, 8'h06, "row_one");
        pulse_check(16'h0017, 8'h02, "row_two");

        // Dead time: fires at decision edges 3, 54, 105 -> pulses at 4..7, 55..58, 106..109
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        sb_push("clr_bin16", 32'd0);
        read_bin(16, v);
        sb_check(32'(v));
        disable_all();
        coincidence_time = 8'd10;
        out_width        = 8'd4;
        set_trig(0, 2'd0, 1, 50);
        for (int c = 0; c < 120; c++) begin
            coax_in[0] = (c % 10 == 0 && c <= 100) ? 1'b0 : 1'b1;
            sb_push($sformatf("dead_c%0d", c),
                    ((c >= 4 && c <= 7) || (c >= 55 && c <= 58) || (c >= 106 && c <= 109))
                    ? 32'd1 : 32'd0);
            tick();
            sb_check(32'(trig_out));
        end
        coax_in = '1;
        idle(5);
        sb_push("dead_bin0", 32'd11);
        read_bin(0, v);
        sb_check(32'(v));
        sb_push("dead_bin16", 32'd3);
        read_bin(16, v);
        sb_check(32'(v));
        chk_eq("dead_toggle", 32'(fire_toggle), 32'd0);

        // Prescale gating
        disable_all();
        coincidence_time = 8'd3;
        out_width        = 8'd4;
        set_trig(0, 2'd0, 1, 0);
        set_trig(1, 2'd0, 1, 0);
        prescale_en = 8'h01;
        randnum     = 32'd5;
        prescale    = 32'd0;
        idle(4);
        pulse_check(16'h0001, 8'h02, "psc_block");
        prescale = 32'd5;
        idle(4);
        pulse_check(16'h0001, 8'h03, "psc_pass");
        chk_eq("psc_toggle", 32'(fire_toggle), 32'd1);

        // Saturation, out-of-range readout, resethist priority
        disable_all();
        resethist = 1'b1;
        tick();
        resethist = 1'b0;
        for (int i = 0; i < 15; i++)
            pulse_hit(3);
        idle(3);
        sb_push("sat_full", 32'd15);
        read_bin(3, v);
        sb_check(32'(v));
        for (int i = 0; i < 3; i++)
            pulse_hit(3);
        idle(3);
        sb_push("sat_hold", 32'd15);
        read_bin(3, v);
        sb_check(32'(v));
        sb_push("sel_oor", 32'd0);
        read_bin(NBIN, v);
        sb_check(32'(v));
        sb_push("sel_255", 32'd0);
        read_bin(255, v);
        sb_check(32'(v));
        resethist  = 1'b1;
        coax_in[3] = 1'b0;
        tick();
        coax_in = '1;
        tick();
        resethist = 1'b0;
        idle(2);
        sb_push("sat_clr", 32'd0);
        read_bin(3, v);
        sb_check(32'(v));

        // Reset mid-pulse
        disable_all();
        coincidence_time = 8'd3;
        out_width        = 8'd16;
        set_trig(0, 2'd0, 1, 0);
        hist_sel   = 8'd16;
        coax_in[0] = 1'b0;
        for (int i = 0; i <= 6; i++)
            sb_push($sformatf("mid_e%0d", i), (i >= 4) ? 32'd1 : 32'd0);
        for (int i = 0; i <= 6; i++) begin
            tick();
            if (i == 0)
                coax_in = '1;
            sb_check(32'(trig_out));
        end
        chk_eq("mid_hist", 32'(hist_out), 32'd1);
        nrst = 1'b0;
        tick();
        chk_eq("mid_rst_trig", 32'(trig_out), 32'd0);
        chk_eq("mid_rst_hist", 32'(hist_out), 32'd0);
        chk_eq("mid_rst_toggle", 32'(fire_toggle), 32'd0);
        nrst = 1'b1;
        idle(2);
        sb_push("mid_bin16", 32'd0);
        read_bin(16, v);
        sb_check(32'(v));

        // Rolling trigger
        disable_all();
        dorolling = 1'b1;
`ifdef ROLLING_TRIG_EN
        t = 0;
        while (!ext_trig_out && t < 40) begin
            t++;
            tick();
        end
        chk_eq("roll_seen", 32'(ext_trig_out), 32'd1);
        hi = 0;
        while (ext_trig_out && hi < 10) begin
            hi++;
            tick();
        end
        chk_eq("roll_high", 32'(hi), 32'd4);
        lo = 0;
        while (!ext_trig_out && lo < 40) begin
            lo++;
            tick();
        end
        chk_eq("roll_period", 32'(hi + lo), 32'd17);
`else
        hi = 0;
        lo = 0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ext_trig_out)
                hi++;
        end
        chk_eq("roll_off", 32'(hi + lo + t), 32'd0);
`endif
        dorolling = 1'b0;
        chk_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
